// File: rtl/tick_generator.sv
// Multi-channel programmable tick / square-wave generator with glitch-free divisor updates.
// Define TICK_GEN_SQUARE_EN to build the sq outputs; otherwise sq is tied low.
module tick_generator #(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 50_000_000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  input  logic              cfg_valid_i,
  input  logic [3:0]        cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_div_i,
  output logic              cfg_ready_o,
  output logic              cfg_err_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] sq_o
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [CNT_W-1:0]  div_q      [NUM_CH];
  logic [CNT_W-1:0]  div_d      [NUM_CH];
  logic [CNT_W-1:0]  pend_div_q [NUM_CH];
  logic [CNT_W-1:0]  pend_div_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] apply;
  logic              cfg_err_q, cfg_err_d;
  logic              ch_valid, pend_sel, accept;

  // Out-of-range channel indices never touch the per-channel arrays.
  always_comb begin
    ch_valid = ({1'b0, cfg_ch_i} < 5'(NUM_CH));
    pend_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch_i == 4'(i)) pend_sel = pend_q[i];
    end
    cfg_ready_o = ch_valid && !pend_sel;
    accept      = cfg_valid_i && cfg_ready_o;
    cfg_err_d   = cfg_valid_i && (!ch_valid || (accept && (cfg_div_i < CNT_W'(2))));
  end

  // A pending divisor is applied only at a period boundary: sync, disable or wrap.
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    tick_d     = '0;
    apply      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync_i || !en_i[i]) begin
        cnt_d[i] = '0;
        apply[i] = pend_q[i];
      end else if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        apply[i]  = pend_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      if (apply[i]) begin
        div_d[i]  = pend_div_q[i];
        pend_d[i] = 1'b0;
      end
      if (accept && (cfg_ch_i == 4'(i)) && (cfg_div_i >= CNT_W'(2))) begin
        pend_d[i]     = 1'b1;
        pend_div_d[i] = cfg_div_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]      <= '0;
        div_q[i]      <= DefDiv;
        pend_div_q[i] <= '0;
      end
      pend_q    <= '0;
      tick_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign tick_o    = tick_q;
  assign cfg_err_o = cfg_err_q;

`ifdef TICK_GEN_SQUARE_EN
  logic [NUM_CH-1:0] sq_q, sq_d;

  // High for the first floor(div/2) counts of each period, using the post-edge divisor.
  always_comb begin
    sq_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sq_d[i] = en_i[i] && (cnt_d[i] < (div_d[i] >> 1));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sq_q <= '0;
    else         sq_q <= sq_d;
  end

  assign sq_o = sq_q;
`else
  assign sq_o = '0;
`endif

endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator (NUM_CH=3, CNT_W=8, DEFAULT_DIV=4).
// Expected behaviour comes from a time-based model of each channel's period start.
module tb_tick_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] en = '0;
  logic       sync = 1'b0;
  logic       cfgValid = 1'b0;
  logic [3:0] cfgCh = '0;
  logic [7:0] cfgDiv = '0;
  logic       cfgReady, cfgErr;
  logic [2:0] tick, sq;

  int vectors = 0;
  int miscompares = 0;

  // Model: each channel remembers the edge index at which its current period began.
  int tEdge = 0;
  int mT0[3];
  int mDiv[3];
  int mPendDiv[3];
  bit mPend[3];
  bit mAccepted;
  logic [2:0] expTick, expSq;
  logic expErr;

  tick_generator #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .sync_i(sync),
    .cfg_valid_i(cfgValid), .cfg_ch_i(cfgCh), .cfg_div_i(cfgDiv),
    .cfg_ready_o(cfgReady), .cfg_err_o(cfgErr), .tick_o(tick), .sq_o(sq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit modelReady(input int ch);
    return (ch < 3) && !mPend[ch];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mT0[i] = tEdge; mDiv[i] = 4; mPendDiv[i] = 0; mPend[i] = 1'b0;
    end
    expTick = '0; expSq = '0; expErr = 1'b0;
  endtask

  task automatic modelEdge();
    bit rdy, restart[3];
    int cur;
    rdy = modelReady(int'(cfgCh));
    expErr = cfgValid && ((cfgCh >= 3) || (rdy && cfgDiv < 2));
    mAccepted = cfgValid && rdy && (cfgDiv >= 2);
    for (int i = 0; i < 3; i++) begin
      cur = tEdge - mT0[i];
      restart[i] = sync || !en[i] || (cur == mDiv[i] - 1);
      expTick[i] = !sync && en[i] && (cur == mDiv[i] - 1);
      if (restart[i] && mPend[i]) begin
        mDiv[i] = mPendDiv[i]; mPend[i] = 1'b0;
      end
    end
    if (mAccepted) begin
      mPend[cfgCh] = 1'b1; mPendDiv[cfgCh] = int'(cfgDiv);
    end
    tEdge++;
    for (int i = 0; i < 3; i++) begin
      if (restart[i]) mT0[i] = tEdge;
      expSq[i] = en[i] && ((tEdge - mT0[i]) < mDiv[i] / 2);
    end
  endtask

  // Drives one cycle of inputs, checks ready before the edge and registered outputs after it.
  task automatic applyStimulus(input logic [2:0] e, input logic s, input logic v,
                               input logic [3:0] ch, input logic [7:0] d);
    logic [2:0] sqRef;
    en = e; sync = s; cfgValid = v; cfgCh = ch; cfgDiv = d;
    #3;
    checkOutput("cfg_ready", 32'(cfgReady), 32'(modelReady(int'(ch))));
    @(posedge clk);
    modelEdge();
    #1;
`ifdef TICK_GEN_SQUARE_EN
    sqRef = expSq;
`else
    sqRef = '0;
`endif
    checkOutput("tick", 32'(tick), 32'(expTick));
    checkOutput("sq", 32'(sq), 32'(sqRef));
    checkOutput("cfg_err", 32'(cfgErr), 32'(expErr));
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_tick"}, 32'(tick), 32'd0);
    checkOutput({tag, "_sq"}, 32'(sq), 32'd0);
    checkOutput({tag, "_err"}, 32'(cfgErr), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(3'b111, 1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  // Holds a request until the model accepts it; a bounded stall.
  task automatic writeHold(input logic [3:0] ch, input logic [7:0] d);
    bit done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      applyStimulus(3'b111, 1'b0, 1'b1, ch, d);
      done = mAccepted;
    end
    cfgValid = 1'b0;
    if (!done) begin
      miscompares++;
      $error("[TB] FAIL writeHold observed=stalled expected=accepted");
    end
  endtask

  initial begin
    modelReset();
    @(posedge clk); #1;
    checkZero("reset");
    reset = 1'b0;

    // All channels in phase at the default divisor.
    idle(12);

    // Mid-period divisor write on ch1, then a second write that must stall.
    idle(1);
    applyStimulus(3'b111, 1'b0, 1'b1, 4'd1, 8'd7);
    writeHold(4'd1, 8'd5);
    idle(20);

    // Rejected requests: divisor below 2 and an out-of-range channel.
    applyStimulus(3'b111, 1'b0, 1'b1, 4'd2, 8'd1);
    applyStimulus(3'b111, 1'b0, 1'b0, 4'd0, 8'd0);
    applyStimulus(3'b111, 1'b0, 1'b1, 4'd5, 8'd9);
    idle(6);

    // Divisors 4,6,4, then a sync landing exactly on a ch0 wrap.
    writeHold(4'd1, 8'd6);
    idle(14);
    for (int k = 0; k < 10 && (tEdge - mT0[0]) != mDiv[0] - 1; k++) idle(1);
    applyStimulus(3'b111, 1'b1, 1'b0, 4'd0, 8'd0);
    idle(14);

    // Asynchronous reset while a divisor is pending.
    writeHold(4'd0, 8'd9);
    idle(1);
    reset = 1'b1;
    #1;
    checkZero("asyncReset");
    modelReset();
    @(posedge clk); #1;
    checkZero("resetHold");
    reset = 1'b0;
    idle(10);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      logic [2:0] e;
      e = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom_range(0, 7));
      applyStimulus(e, ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0),
                    4'($urandom_range(0, 5)), 8'($urandom_range(0, 9)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tick_generator.md
# tick_generator

Parametrised multi-channel tick and square-wave generator; the next generation of the parking system's fixed-rate divider. Each of NUM_CH channels divides the single system clock by a run-time programmable divisor. It produces a one-cycle enable strobe for synchronous consumers and an optional near-50% square wave for LED/display/buzzer drive. Divisor changes are glitch-free, and a global sync input realigns all channels.

## Interface
- NUM_CH, 3: number of independent channels (1..16)
- CNT_W, 26: counter and divisor width in bits
- DEFAULT_DIV, 50_000_000: divisor loaded into every channel at reset; 2 <= DEFAULT_DIV < 2**CNT_W
- clk  input  1  system clock; single clock domain
- reset  input  1  asynchronous, active-high reset
- en  input  NUM_CH  per-channel run enable
- sync  input  1  one-cycle pulse; realigns all channels
- cfg_valid  input  1  divisor update request
- cfg_ch  input  4  target channel index
- cfg_div  input  CNT_W  new divisor
- cfg_ready  output  1  update can be accepted (combinational)
- cfg_err  output  1  registered one-cycle pulse; last request rejected
- tick  output  NUM_CH  registered one-cycle strobe per period
- sq  output  NUM_CH  registered square wave

## Operation
- Per-channel state: cnt (CNT_W), div (CNT_W), pend_div (CNT_W), pend (1).
- Reset values: cnt=0, div=DEFAULT_DIV, pend=0, pend_div=0; tick=0, sq=0, cfg_err=0.
- Channel with en[i]=0: cnt←0, tick[i]←0, sq[i]←0. If pend[i]=1: div←pend_div, pend←0.
- Channel with en[i]=1 and cnt≠div−1: cnt←cnt+1, tick[i]←0.
- Channel with en[i]=1 and cnt=div−1 (wrap): cnt←0, tick[i]←1. If pend[i]=1: div←pend_div, pend←0.
- sq[i]←1 when the next cnt value < floor(div/2), else 0. This uses the div in effect after the edge. Period = div cycles; high time = floor(div/2).
- Config handshake: cfg_ready = (cfg_ch < NUM_CH) && !pend[cfg_ch]. A transfer occurs when cfg_valid && cfg_ready.
  - Accepted with cfg_div >= 2: pend_div←cfg_div, pend←1.
  - Accepted with cfg_div < 2: dropped, cfg_err←1.
- cfg_ch >= NUM_CH with cfg_valid: cfg_ready=0 and cfg_err←1. The requester must deassert cfg_valid or change cfg_ch.
- cfg_valid held while cfg_ready=0 on a valid channel: the request stalls with no error.
- Accept and wrap in the same cycle on the same channel: the new divisor becomes pending and applies at the following wrap, not the current one.
- sync=1 at an edge: every channel sets cnt←0, tick←0, and applies any pending divisor immediately. Enabled channels then count from 0 together. sync overrides a coincident wrap, so no tick is produced.
- reset mid-period: all state returns to reset values asynchronously. No tick or sq glitch high follows deassertion.

## Timing
- Steady state: tick[i] is high exactly 1 cycle in every div[i] cycles.
- en[i] rises and is first sampled high at edge 0: the first tick is registered at edge div−1. tick is visible div−1 cycles after the first enabled edge.
- A divisor accepted at edge k with no wrap at k takes effect at the first wrap after k. The period containing edge k keeps its old length.
- On a disabled channel, an accepted divisor is applied on the next edge.
- cfg_err goes high the cycle after the offending request and lasts 1 cycle per offending edge.
- The sync edge is followed by the first tick div cycles later, simultaneously on all enabled channels with equal div.
- No combinational path exists from en or sync to any output. cfg_ready depends only on cfg_ch and pend.

## Configuration
- TICK_GEN_SQUARE_EN defined: sq outputs are generated as specified.
- TICK_GEN_SQUARE_EN undefined: sq is tied to 0, and the sq comparison logic is not synthesised.
- tick, cfg and sync behaviour is identical in both builds.

## Test plan
All scenarios use NUM_CH=3, CNT_W=8, DEFAULT_DIV=4, with TICK_GEN_SQUARE_EN defined.
- Reset release, en=3'b111 → tick on all channels every 4 cycles, in phase; sq pattern 1100 repeating.
- en[1] held high; write ch1 div=7 mid-period → current period stays 4 cycles. Subsequent periods are 7 cycles; sq[1] high 3, low 4. Channels 0 and 2 are unaffected.
- Second write to ch1 while pend[1]=1 → cfg_ready=0; the request stalls until the wrap, then is accepted.
- Write ch2 div=1, then cfg_ch=5 → cfg_err pulses once for each; divisors are unchanged.
- Channels running with div=4, 6, 4; sync pulse → all cnt=0. First ticks occur 4 cycles later on ch0 and ch2, and 6 cycles later on ch1. No tick occurs on the sync edge even when it coincides with a wrap.
- reset asserted mid-count with a divisor pending → outputs go to 0 immediately; the pending update is lost and div returns to 4.
